// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with a programmable terminal value.
// The counter supports synchronous clear, parallel load with a sticky illegal-load flag, and a combinational carry/borrow.
module bcd_counter_n #(
  parameter int                    DIGITS = 2,
  parameter logic [4*DIGITS-1:0]   TOP    = 8'h59
) (
  input  logic                     Clk,
  input  logic                     Rn,
  input  logic                     Clr,
  input  logic                     Ld,
  input  logic [4*DIGITS-1:0]      D,
  input  logic                     En,
  input  logic                     Up,
  output logic [4*DIGITS-1:0]      Q,
  output logic                     Co,
  output logic                     Err
);

  localparam int W = 4 * DIGITS;

  // True when every nibble of v is a decimal digit.
  function automatic logic digits_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple a +1 through the digits; each digit wraps 9 -> 0 independently.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] q_q, q_d;
  logic         err_q, err_d;
  logic         at_top, at_zero, load_ok;

  assign at_top  = (q_q == TOP);
  assign at_zero = (q_q == '0);
  // With legal digits, an unsigned compare of packed BCD orders values decimally.
  assign load_ok = digits_legal(D) && (D <= TOP);

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (Clr) begin
      q_d   = '0;
      err_d = 1'b0;
    end else if (Ld) begin
      if (load_ok) begin
        q_d = D;
      end else begin
        q_d   = '0;
        err_d = 1'b1;
      end
    end else if (En) begin
      if (Up) q_d = at_top  ? '0  : bcd_inc(q_q);
      else    q_d = at_zero ? TOP : bcd_dec(q_q);
    end
  end

  always_ff @(posedge Clk or negedge Rn) begin
    if (!Rn) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign Err = err_q;
  assign Co  = En & ~Clr & ~Ld & (Up ? at_top : at_zero);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: a 2-digit clock-style instance (TOP = 59)
// and a 3-digit instance (TOP = 999) with a random up/down run against a decimal model.
module tb_bcd_counter_n;

  logic        Clk, Rn;
  logic        clr2, ld2, en2, up2;
  logic [7:0]  d2, q2;
  logic        co2, err2;
  logic        clr3, ld3, en3, up3;
  logic [11:0] d3, q3;
  logic        co3, err3;

  int pass_cnt;
  int check_cnt;
  int model3;

  bcd_counter_n #(.DIGITS(2), .TOP(8'h59)) dut2 (
    .Clk(Clk), .Rn(Rn), .Clr(clr2), .Ld(ld2), .D(d2), .En(en2), .Up(up2),
    .Q(q2), .Co(co2), .Err(err2)
  );

  bcd_counter_n #(.DIGITS(3), .TOP(12'h999)) dut3 (
    .Clk(Clk), .Rn(Rn), .Clr(clr3), .Ld(ld3), .D(d3), .En(en3), .Up(up3),
    .Q(q3), .Co(co3), .Err(err3)
  );

  // Clock and reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic all_digits_ok(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    Rn = 1'b0;
    {clr2, ld2, en2, up2} = '0; d2 = '0;
    {clr3, ld3, en3, up3} = '0; d3 = '0;
    #12;
    Rn = 1'b1;
    tick();
    check("reset_q", 32'(q2), 32'h00);
    check("reset_err", 32'(err2), 32'h0);

    // Test 1: asynchronous reset mid-count, with Err previously set
    ld2 = 1'b1; d2 = 8'hA0;
    tick();
    check("t1_illegal_q", 32'(q2), 32'h00);
    check("t1_illegal_err", 32'(err2), 32'h1);
    d2 = 8'h37;
    tick();
    check("t1_load37", 32'(q2), 32'h37);
    ld2 = 1'b0;
    #2;
    Rn = 1'b0;
    #1;
    check("t1_async_q", 32'(q2), 32'h00);
    check("t1_async_err", 32'(err2), 32'h0);
    Rn = 1'b1;
    en2 = 1'b1; up2 = 1'b1;
    tick();
    check("t1_first_edge", 32'(q2), 32'h01);

    // Test 2: up-count across the terminal value
    en2 = 1'b0; ld2 = 1'b1; d2 = 8'h58;
    tick();
    check("t2_load58", 32'(q2), 32'h58);
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    #1;
    check("t2_co_at58", 32'(co2), 32'h0);
    tick();
    check("t2_q59", 32'(q2), 32'h59);
    check("t2_co_at59", 32'(co2), 32'h1);
    tick();
    check("t2_q00", 32'(q2), 32'h00);
    check("t2_co_at00", 32'(co2), 32'h0);
    tick();
    check("t2_q01", 32'(q2), 32'h01);

    // Test 3: down-count with borrow, wrap from 00 to TOP, direction reversals
    en2 = 1'b0; ld2 = 1'b1; d2 = 8'h10;
    tick();
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b0;
    tick();
    check("t3_q09", 32'(q2), 32'h09);
    tick();
    check("t3_q08", 32'(q2), 32'h08);
    tick();
    check("t3_q07", 32'(q2), 32'h07);
    en2 = 1'b0; ld2 = 1'b1; d2 = 8'h00;
    tick();
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b0;
    #1;
    check("t3_co_at00_down", 32'(co2), 32'h1);
    tick();
    check("t3_wrap59", 32'(q2), 32'h59);
    check("t3_co_at59_down", 32'(co2), 32'h0);
    tick();
    check("t3_rev_58", 32'(q2), 32'h58);
    en2 = 1'b0; ld2 = 1'b1; d2 = 8'h00;
    tick();
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    tick();
    check("t3_rev_01", 32'(q2), 32'h01);

    // Test 4: sticky Err across illegal loads
    en2 = 1'b0; ld2 = 1'b1; d2 = 8'h6A;
    tick();
    check("t4_6A_q", 32'(q2), 32'h00);
    check("t4_6A_err", 32'(err2), 32'h1);
    d2 = 8'h12;
    tick();
    check("t4_12_q", 32'(q2), 32'h12);
    check("t4_12_err", 32'(err2), 32'h1);
    d2 = 8'h60;
    tick();
    check("t4_60_q", 32'(q2), 32'h00);
    ld2 = 1'b0; clr2 = 1'b1;
    tick();
    check("t4_clr_q", 32'(q2), 32'h00);
    check("t4_clr_err", 32'(err2), 32'h0);
    clr2 = 1'b0;

    // Test 5: priority Clr > Ld > En, and hold
    ld2 = 1'b1; d2 = 8'h59;
    tick();
    en2 = 1'b1; up2 = 1'b1;
    #1;
    check("t5_co_ld_mask", 32'(co2), 32'h0);
    ld2 = 1'b0; d2 = 8'h33; ld2 = 1'b1; en2 = 1'b0;
    tick();
    check("t5_load33", 32'(q2), 32'h33);
    clr2 = 1'b1; ld2 = 1'b1; en2 = 1'b1;
    #1;
    check("t5_co_clr", 32'(co2), 32'h0);
    tick();
    check("t5_clr_wins", 32'(q2), 32'h00);
    clr2 = 1'b0; d2 = 8'h20;
    tick();
    check("t5_ld_wins", 32'(q2), 32'h20);
    ld2 = 1'b0; en2 = 1'b0;
    tick();
    tick();
    check("t5_hold", 32'(q2), 32'h20);

    // Test 6: three-digit carry and wrap
    ld3 = 1'b1; d3 = 12'h099;
    tick();
    ld3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    tick();
    check("t6_q100", 32'(q3), 32'h100);
    en3 = 1'b0; ld3 = 1'b1; d3 = 12'h999;
    tick();
    ld3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    #1;
    check("t6_co_999", 32'(co3), 32'h1);
    tick();
    check("t6_q000", 32'(q3), 32'h000);
    en3 = 1'b0; clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    model3 = 0;
    for (int i = 0; i < 2000; i++) begin
      en3 = 1'($urandom_range(0, 1));
      up3 = 1'($urandom_range(0, 1));
      if (en3) begin
        if (up3) model3 = (model3 == 999) ? 0 : model3 + 1;
        else     model3 = (model3 == 0) ? 999 : model3 - 1;
      end
      tick();
      check("t6_rand_digits", 32'(all_digits_ok(q3)), 32'h1);
      check("t6_rand_model", 32'(q3), 32'(to_bcd3(model3)));
    end
    check("t6_err_clear", 32'(err3), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
